// File: rtl/ysyx_mem_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// Owner ids double as the round-robin last-grant encoding.
package ysyx_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [3:0] WMASK_B = 4'b0001;
    localparam logic [3:0] WMASK_H = 4'b0011;
    localparam logic [3:0] WMASK_W = 4'b1111;

endpackage

// File: rtl/ysyx_mem_arbiter_chk.sv
// Simulation checks on the arbiter: exclusive accepts, responses only while waiting.
module ysyx_mem_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic in_wait,
    input logic mem_resp_valid,
    input logic ifu_req_ready,
    input logic lsu_req_ready
);

    a_excl_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !(ifu_req_ready && lsu_req_ready));

    a_resp_in_wait : assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_resp_valid && !in_wait));

endmodule

// File: rtl/ysyx_rr_arb2.sv
// Two-way round-robin picker: req[0]=IFU, req[1]=LSU, one-hot grant.
// On a tie the requester that was not granted last time wins.
module ysyx_rr_arb2
    import ysyx_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_grant,
    output logic [1:0] grant
);

    // Combinational grant selection
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, one transaction
// at a time, with round-robin arbitration and a stuck-transaction timeout.
module ysyx_mem_arbiter
    import ysyx_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic              ifu_resp_err,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic              lsu_resp_err,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int             CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit             TO_EN   = (TIMEOUT_CYC != 0);

    state_e            state_r, state_s;
    owner_e            owner_r, last_grant_r;
    logic [1:0]        grant_s;
    logic              accept_s, busy_s, expire_s, resp_ok_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              err_r;
    logic [DATA_W-1:0] ifu_rdata_r, lsu_rdata_r;

    ysyx_rr_arb2 u_arb (
        .req        ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    assign ifu_req_ready = (state_r == ST_IDLE) && grant_s[0];
    assign lsu_req_ready = (state_r == ST_IDLE) && grant_s[1];
    assign accept_s      = ifu_req_ready || lsu_req_ready;
    assign busy_s        = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
    assign expire_s      = TO_EN && busy_s && (cnt_r == CNT_MAX);
    assign resp_ok_s     = (state_r == ST_WAIT) && mem_resp_valid;

    // Next-state logic; a response in the expiry cycle beats the timeout
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_ISSUE;
                else          state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (expire_s)           state_s = ST_RESP;
                else if (mem_req_ready) state_s = ST_WAIT;
                else                    state_s = ST_ISSUE;
            end
            ST_WAIT: begin
                if (mem_resp_valid || expire_s) state_s = ST_RESP;
                else                            state_s = ST_WAIT;
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Latch the winning request and remember who won for the next tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r      <= OWN_IFU;
            last_grant_r <= OWN_LSU;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wen      <= 1'b0;
            mem_wdata    <= {DATA_W{1'b0}};
            mem_wmask    <= 4'b0000;
        end else if (accept_s) begin
            owner_r      <= grant_s[1] ? OWN_LSU : OWN_IFU;
            last_grant_r <= grant_s[1] ? OWN_LSU : OWN_IFU;
            mem_addr     <= grant_s[1] ? lsu_addr : ifu_addr;
            mem_wen      <= grant_s[1] ? lsu_wen : 1'b0;
            mem_wdata    <= grant_s[1] ? lsu_wdata : {DATA_W{1'b0}};
            mem_wmask    <= grant_s[1] ? lsu_wmask : 4'b0000;
        end else begin
            owner_r      <= owner_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Timeout counter, restarted on every accept and saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           cnt_r <= {CNT_W{1'b0}};
        else if (accept_s)                    cnt_r <= {CNT_W{1'b0}};
        else if (busy_s && (cnt_r != CNT_MAX)) cnt_r <= cnt_r + CNT_W'(1);
        else                                  cnt_r <= cnt_r;
    end

    // Capture response data for the owner; stores and timeouts return zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r       <= 1'b0;
            ifu_rdata_r <= {DATA_W{1'b0}};
            lsu_rdata_r <= {DATA_W{1'b0}};
        end else if (resp_ok_s) begin
            err_r <= 1'b0;
            if (owner_r == OWN_IFU) ifu_rdata_r <= mem_rdata;
            else                    lsu_rdata_r <= mem_wen ? {DATA_W{1'b0}} : mem_rdata;
        end else if (expire_s) begin
            err_r <= 1'b1;
            if (owner_r == OWN_IFU) ifu_rdata_r <= {DATA_W{1'b0}};
            else                    lsu_rdata_r <= {DATA_W{1'b0}};
        end else begin
            err_r <= err_r;
        end
    end

    assign mem_req_valid  = (state_r == ST_ISSUE);
    assign ifu_resp_valid = (state_r == ST_RESP) && (owner_r == OWN_IFU);
    assign lsu_resp_valid = (state_r == ST_RESP) && (owner_r == OWN_LSU);
    assign ifu_resp_err   = ifu_resp_valid && err_r;
    assign lsu_resp_err   = lsu_resp_valid && err_r;
    assign ifu_rdata      = ifu_rdata_r;
    assign lsu_rdata      = lsu_rdata_r;

    ysyx_mem_arbiter_chk u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_wait        (state_r == ST_WAIT),
        .mem_resp_valid (mem_resp_valid),
        .ifu_req_ready  (ifu_req_ready),
        .lsu_req_ready  (lsu_req_ready)
    );

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed bench for ysyx_mem_arbiter with a short timeout (8 cycles).
module tb_ysyx_mem_arbiter;
    import ysyx_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask, mem_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
        lsu_wdata = 32'h0; lsu_wmask = 4'b0000;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_ifu_resp_valid", {31'd0, ifu_resp_valid}, 32'd0);
        chk("rst_lsu_resp_valid", {31'd0, lsu_resp_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // IFU alone, memory ready at once, response two cycles later
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #1;
        chk("t2_ifu_ready", {31'd0, ifu_req_ready}, 32'd1);
        chk("t2_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
        tick();                                     // T+1
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        chk("t2_mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("t2_mem_addr", mem_addr, 32'h8000_0000);
        chk("t2_mem_wen", {31'd0, mem_wen}, 32'd0);
        tick();                                     // T+2
        mem_req_ready = 1'b0;
        chk("t2_mem_req_drop", {31'd0, mem_req_valid}, 32'd0);
        tick();                                     // T+3
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        chk("t2_no_early_resp", {31'd0, ifu_resp_valid}, 32'd0);
        tick();                                     // T+4
        mem_resp_valid = 1'b0;
        chk("t2_ifu_resp_valid", {31'd0, ifu_resp_valid}, 32'd1);
        chk("t2_ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("t2_ifu_resp_err", {31'd0, ifu_resp_err}, 32'd0);
        chk("t2_lsu_resp_valid", {31'd0, lsu_resp_valid}, 32'd0);
        tick();                                     // T+5
        chk("t2_pulse_one_cycle", {31'd0, ifu_resp_valid}, 32'd0);

        // LSU load interrupted by reset while in WAIT
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0010; lsu_wen = 1'b0; lsu_wmask = WMASK_W;
        #1;
        chk("t1_lsu_ready", {31'd0, lsu_req_ready}, 32'd1);
        tick();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t1_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("t1_mem_addr", mem_addr, 32'h0);
        chk("t1_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        chk("t1_ifu_rdata", ifu_rdata, 32'h0);
        chk("t1_lsu_req_ready", {31'd0, lsu_req_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_no_lsu_resp", {31'd0, lsu_resp_valid}, 32'd0);
            chk("t1_no_ifu_resp", {31'd0, ifu_resp_valid}, 32'd0);
            tick();
        end

        // Both request after reset: IFU wins first, LSU next
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
        #1;
        chk("t3_first_ifu_ready", {31'd0, ifu_req_ready}, 32'd1);
        chk("t3_first_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
        tick();
        mem_req_ready = 1'b1;
        chk("t3_first_addr", mem_addr, 32'h8000_0100);
        chk("t3_no_accept_busy", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_resp_valid = 1'b0;
        chk("t3_ifu_resp", {31'd0, ifu_resp_valid}, 32'd1);
        chk("t3_ifu_rdata", ifu_rdata, 32'h1111_1111);
        tick();
        chk("t3_second_lsu_ready", {31'd0, lsu_req_ready}, 32'd1);
        chk("t3_second_ifu_ready", {31'd0, ifu_req_ready}, 32'd0);
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        chk("t3_second_addr", mem_addr, 32'h8000_0200);
        chk("t3_second_wen", {31'd0, mem_wen}, 32'd0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        mem_resp_valid = 1'b0;
        chk("t3_lsu_resp", {31'd0, lsu_resp_valid}, 32'd1);
        chk("t3_lsu_rdata", lsu_rdata, 32'h2222_2222);
        chk("t3_ifu_quiet", {31'd0, ifu_resp_valid}, 32'd0);
        tick();

        // LSU byte store; ack returns zero data
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hdead_beef; lsu_wmask = WMASK_B;
        #1;
        chk("t4_lsu_ready", {31'd0, lsu_req_ready}, 32'd1);
        tick();
        lsu_req_valid = 1'b0; lsu_wdata = 32'h0; lsu_wen = 1'b0; lsu_wmask = 4'b0000;
        mem_req_ready = 1'b1;
        chk("t4_mem_addr", mem_addr, 32'h8000_1000);
        chk("t4_mem_wen", {31'd0, mem_wen}, 32'd1);
        chk("t4_mem_wdata", mem_wdata, 32'hdead_beef);
        chk("t4_mem_wmask", {28'd0, mem_wmask}, 32'h0000_0001);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hcafe_f00d;
        tick();
        mem_resp_valid = 1'b0;
        chk("t4_lsu_ack", {31'd0, lsu_resp_valid}, 32'd1);
        chk("t4_lsu_rdata", lsu_rdata, 32'h0);
        chk("t4_lsu_err", {31'd0, lsu_resp_err}, 32'd0);
        tick();

        // Memory stalls the request for three cycles
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_2000;
        #1;
        chk("t5_ifu_ready", {31'd0, ifu_req_ready}, 32'd1);
        tick();
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_9999; lsu_wen = 1'b0;
        ifu_addr = 32'h8000_7777;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_hold_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("t5_hold_addr", mem_addr, 32'h8000_2000);
            chk("t5_no_accept", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        chk("t5_still_valid", {31'd0, mem_req_valid}, 32'd1);
        tick();
        mem_req_ready = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h55aa_55aa;
        tick();
        mem_resp_valid = 1'b0;
        chk("t5_ifu_resp", {31'd0, ifu_resp_valid}, 32'd1);
        chk("t5_ifu_rdata", ifu_rdata, 32'h55aa_55aa);
        chk("t5_ifu_err", {31'd0, ifu_resp_err}, 32'd0);
        tick();

        // IFU fetch with no response: timeout error at accept+9
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_3000;
        #1;
        chk("t6a_ifu_ready", {31'd0, ifu_req_ready}, 32'd1);
        tick();                                     // T+1
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();                                     // T+2
        mem_req_ready = 1'b0;
        repeat (7) begin                            // T+2 .. T+8
            chk("t6a_no_early_resp", {31'd0, ifu_resp_valid}, 32'd0);
            tick();
        end
        chk("t6a_resp_valid", {31'd0, ifu_resp_valid}, 32'd1);
        chk("t6a_resp_err", {31'd0, ifu_resp_err}, 32'd1);
        chk("t6a_rdata_zero", ifu_rdata, 32'h0);
        chk("t6a_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        tick();
        chk("t6a_pulse_end", {31'd0, ifu_resp_valid}, 32'd0);
        chk("t6a_err_end", {31'd0, ifu_resp_err}, 32'd0);

        // Response in the expiry cycle wins over the timeout
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4000; lsu_wen = 1'b0; lsu_wmask = WMASK_H;
        #1;
        chk("t6b_lsu_ready", {31'd0, lsu_req_ready}, 32'd1);
        tick();                                     // T+1
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        chk("t6b_mem_wmask", {28'd0, mem_wmask}, 32'h0000_0003);
        tick();                                     // T+2
        mem_req_ready = 1'b0;
        repeat (6) begin                            // T+2 .. T+7
            chk("t6b_no_early_resp", {31'd0, lsu_resp_valid}, 32'd0);
            tick();
        end
        mem_resp_valid = 1'b1; mem_rdata = 32'h0bad_f00d; // T+8
        tick();                                     // T+9
        mem_resp_valid = 1'b0;
        chk("t6b_resp_valid", {31'd0, lsu_resp_valid}, 32'd1);
        chk("t6b_resp_err", {31'd0, lsu_resp_err}, 32'd0);
        chk("t6b_rdata", lsu_rdata, 32'h0bad_f00d);
        tick();
        chk("t6b_pulse_end", {31'd0, lsu_resp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
